// File: rtl/tick_gen.sv
// Parametrised timebase: divides clk into second, half-second, blink and minute
// pulses, with a per-mode divisor (normal, fast-set, test) and a pause mode.
module tick_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int FAST_HZ  = 8,
  parameter int TEST_DIV = 10,
  parameter int CNT_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] counter,
  output logic [5:0]       sec_count,
  output logic             tick_sec,
  output logic             tick_half,
  output logic             blink,
  output logic             tick_min
);

  localparam logic [1:0] MODE_NORM  = 2'b00;
  localparam logic [1:0] MODE_FAST  = 2'b01;
  localparam logic [1:0] MODE_TEST  = 2'b10;
  localparam logic [1:0] MODE_PAUSE = 2'b11;

  localparam int DIV_NORM = CLK_HZ;
  localparam int DIV_FAST = CLK_HZ / FAST_HZ;
  localparam int DIV_TEST = TEST_DIV;

  localparam logic [CNT_W-1:0] NORM_LAST = CNT_W'(DIV_NORM - 1);
  localparam logic [CNT_W-1:0] NORM_HALF = CNT_W'(DIV_NORM / 2 - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] FAST_HALF = CNT_W'(DIV_FAST / 2 - 1);
  localparam logic [CNT_W-1:0] TEST_LAST = CNT_W'(DIV_TEST - 1);
  localparam logic [CNT_W-1:0] TEST_HALF = CNT_W'(DIV_TEST / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] half_cnt;
  logic             mode_change;
  logic             paused;

  always_comb begin
    last_cnt = NORM_LAST;
    half_cnt = NORM_HALF;
    case (mode_q)
      MODE_FAST: begin
        last_cnt = FAST_LAST;
        half_cnt = FAST_HALF;
      end
      MODE_TEST: begin
        last_cnt = TEST_LAST;
        half_cnt = TEST_HALF;
      end
      default: ;
    endcase
  end

  // Selecting pause is not a mode change: mode_q keeps the running divisor so
  // leaving pause resumes the count exactly where it stopped, just like en=0.
  assign mode_change = (mode != mode_q) && (mode != MODE_PAUSE);
  assign paused      = !en || (mode == MODE_PAUSE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      counter   <= '0;
      sec_count <= '0;
      tick_sec  <= 1'b0;
      tick_half <= 1'b0;
      tick_min  <= 1'b0;
      blink     <= 1'b1;
      mode_q    <= mode;
    end else if (mode_change) begin
      counter   <= '0;
      tick_sec  <= 1'b0;
      tick_half <= 1'b0;
      tick_min  <= 1'b0;
      blink     <= 1'b1;
      mode_q    <= mode;
    end else if (paused) begin
      tick_sec  <= 1'b0;
      tick_half <= 1'b0;
      tick_min  <= 1'b0;
    end else if (counter == last_cnt) begin
      counter   <= '0;
      tick_sec  <= 1'b1;
      tick_half <= 1'b1;
      blink     <= 1'b1;
      if (sec_count == 6'd59) begin
        sec_count <= '0;
        tick_min  <= 1'b1;
      end else begin
        sec_count <= sec_count + 6'd1;
        tick_min  <= 1'b0;
      end
    end else if (counter == half_cnt) begin
      counter   <= counter + CNT_ONE;
      tick_sec  <= 1'b0;
      tick_half <= 1'b1;
      tick_min  <= 1'b0;
      blink     <= 1'b0;
    end else begin
      counter   <= counter + CNT_ONE;
      tick_sec  <= 1'b0;
      tick_half <= 1'b0;
      tick_min  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios with literal expectations
// plus randomised bursts, all compared every cycle against a behavioural model.
module tb_tick_gen;

  localparam int CLK_HZ   = 100;
  localparam int FAST_HZ  = 4;
  localparam int TEST_DIV = 10;
  localparam int CNT_W    = 26;

  logic             clk;
  logic             rst;
  logic             en;
  logic             clear;
  logic [1:0]       mode;
  logic [CNT_W-1:0] counter;
  logic [5:0]       sec_count;
  logic             tick_sec;
  logic             tick_half;
  logic             blink;
  logic             tick_min;

  int checks = 0;
  int fails  = 0;
  bit checkEn = 0;
  bit prevTs = 0;

  int         mCnt = 0;
  int         mSec = 0;
  bit         mTs = 0, mTh = 0, mTm = 0;
  logic [1:0] mModeQ = 2'b00;

  tick_gen #(
    .CLK_HZ(CLK_HZ), .FAST_HZ(FAST_HZ), .TEST_DIV(TEST_DIV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode),
    .counter(counter), .sec_count(sec_count), .tick_sec(tick_sec),
    .tick_half(tick_half), .blink(blink), .tick_min(tick_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int divOf(input logic [1:0] m);
    case (m)
      2'b01:   return CLK_HZ / FAST_HZ;
      2'b10:   return TEST_DIV;
      default: return CLK_HZ;
    endcase
  endfunction

  function automatic longint packOut(input int c, input int s, input bit ts,
                                     input bit th, input bit bl, input bit tm);
    return (longint'(c) << 10) | (longint'(s) << 4) | longint'({ts, th, bl, tm});
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic c, input logic [1:0] m);
    rst   = r;
    en    = e;
    clear = c;
    mode  = m;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges until tick_sec is seen; -1 means it never came within the bound.
  task automatic waitTick(input string name, input int expected);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = tick_sec;
    end
    checkOutput(name, seen ? n : -1, expected);
  endtask

  // Reference model: position within the period and seconds modulo 60.
  always @(posedge clk) begin
    int d;
    if (rst || clear) begin
      mCnt = 0; mSec = 0; mTs = 0; mTh = 0; mTm = 0; mModeQ = mode;
    end else if (mode != mModeQ && mode != 2'b11) begin
      mCnt = 0; mTs = 0; mTh = 0; mTm = 0; mModeQ = mode;
    end else if (!en || mode == 2'b11) begin
      mTs = 0; mTh = 0; mTm = 0;
    end else begin
      d = divOf(mModeQ);
      mCnt = (mCnt + 1) % d;
      mTs = (mCnt == 0);
      mTh = (mCnt == 0) || (mCnt == d / 2);
      if (mTs) mSec = (mSec + 1) % 60;
      mTm = mTs && (mSec == 0);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("outputs",
                  packOut(int'(counter), int'(sec_count), tick_sec, tick_half, blink, tick_min),
                  packOut(mCnt, mSec, mTs, mTh, mCnt < divOf(mModeQ) / 2, mTm));
      if (tick_sec) checkOutput("tick_sec_width", longint'(prevTs), 0);
      if (tick_min) checkOutput("min_implies_sec", longint'(tick_sec), 1);
      checkOutput("counter_range", longint'(int'(counter) < divOf(mModeQ)), 1);
      prevTs = tick_sec;
    end
  end

  initial begin
    int pauseTicks;
    int r;
    applyStimulus(1, 1, 0, 2'b00);
    @(posedge clk);
    checkEn = 1;
    stepEdges(5);
    checkOutput("reset_counter", counter, 0);
    checkOutput("reset_sec", sec_count, 0);
    checkOutput("reset_blink", blink, 1);
    checkOutput("reset_ticks", {tick_sec, tick_half, tick_min}, 0);

    // Normal mode latency, half pulse and blink phase.
    applyStimulus(0, 1, 0, 2'b00);
    waitTick("first_tick_norm", 100);
    stepEdges(49);
    checkOutput("blink_first_half", blink, 1);
    checkOutput("no_half_at_49", tick_half, 0);
    stepEdges(1);
    checkOutput("blink_second_half", blink, 0);
    checkOutput("half_at_50", tick_half, 1);
    waitTick("second_tick_norm", 50);

    // Test mode with clear: sec_count walks a full minute.
    applyStimulus(0, 1, 1, 2'b10);
    stepEdges(1);
    applyStimulus(0, 1, 0, 2'b10);
    checkOutput("clear_counter", counter, 0);
    checkOutput("clear_sec", sec_count, 0);
    for (int i = 0; i < 60; i++) begin
      waitTick($sformatf("test_tick_%0d", i), 10);
      checkOutput($sformatf("sec_after_%0d", i), sec_count, (i + 1) % 60);
      checkOutput($sformatf("min_at_%0d", i), tick_min, (i == 59) ? 1 : 0);
    end

    // Clear on the edge that would wrap 59 -> 0.
    for (int i = 0; i < 59; i++) waitTick("to_sec59", 10);
    stepEdges(9);
    checkOutput("pre_clear_counter", counter, 9);
    checkOutput("pre_clear_sec", sec_count, 59);
    applyStimulus(0, 1, 1, 2'b10);
    stepEdges(1);
    applyStimulus(0, 1, 0, 2'b10);
    checkOutput("clear_wrap_ticks", {tick_sec, tick_min}, 0);
    checkOutput("clear_wrap_counter", counter, 0);
    checkOutput("clear_wrap_sec", sec_count, 0);

    // Same point with rst and clear together.
    for (int i = 0; i < 59; i++) waitTick("to_sec59_b", 10);
    stepEdges(9);
    applyStimulus(1, 1, 1, 2'b10);
    stepEdges(1);
    applyStimulus(0, 1, 0, 2'b10);
    checkOutput("rst_wrap_all",
                packOut(int'(counter), int'(sec_count), tick_sec, tick_half, blink, tick_min),
                packOut(0, 0, 0, 0, 1, 0));

    // Fast-set mode, then switch back to normal mid-period.
    applyStimulus(0, 1, 0, 2'b01);
    waitTick("first_tick_fast", 26);
    waitTick("second_tick_fast", 25);
    stepEdges(17);
    checkOutput("fast_counter_17", counter, 17);
    applyStimulus(0, 1, 0, 2'b00);
    stepEdges(1);
    checkOutput("switch_counter", counter, 0);
    checkOutput("switch_no_tick", tick_sec, 0);
    waitTick("tick_after_switch", 100);

    // Pause via en=0 and via mode=11 at counter 40.
    for (int p = 0; p < 2; p++) begin
      stepEdges(40);
      checkOutput("pause_entry_counter", counter, 40);
      if (p == 0) applyStimulus(0, 0, 0, 2'b00);
      else        applyStimulus(0, 1, 0, 2'b11);
      pauseTicks = 0;
      repeat (30) begin
        @(negedge clk);
        pauseTicks += int'(tick_sec) + int'(tick_half) + int'(tick_min);
      end
      checkOutput($sformatf("pause_counter_%0d", p), counter, 40);
      checkOutput($sformatf("pause_ticks_%0d", p), pauseTicks, 0);
      applyStimulus(0, 1, 0, 2'b00);
      waitTick($sformatf("resume_tick_%0d", p), 60);
    end

    // Randomised bursts of en/clear/mode/rst.
    mode = 2'b10;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 999);
      rst   = (r < 5);
      clear = (r >= 5 && r < 25);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
